shared_state_if_unit: RTL and testbench

- Shared-state unit that several client modules reach through one handle.
- Holds one 32-bit signed integer state register, `x`, and exposes it as a read port.
- Provides NUM_Q independent "invert-LSB" query lanes. Each lane takes either an external argument or the stored state, truncates it to 1 bit, and returns the inverse.
- Used wherever clients need a common flag word plus a cheap complement service.

---
 rtl/shared_state_if_unit_pkg.sv | 19 +
 rtl/shared_state_if_unit_inv_lsb_lane.sv | 47 ++++
 rtl/shared_state_if_unit.sv | 51 +++++
 tb/tb_shared_state_if_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_state_if_unit_pkg.sv
// Shared types for the shared-state unit: state word, flag bundle
// and the invert-LSB helper used by every query lane.
package shared_state_pkg;

  localparam int WIDTH = 32;

  typedef logic signed [WIDTH-1:0] state_t;

  typedef struct packed {
    logic x;
  } flag_t;

  function automatic logic inv_lsb(
    input state_t arg
  );
    return ~arg[0];
  endfunction

endpackage

// File: rtl/shared_state_if_unit_inv_lsb_lane.sv
// One invert-LSB query lane: argument mux, inversion and, when
// SHARED_STATE_QUERY_REG_EN is defined, a 1-cycle output register.
module inv_lsb_lane
  import shared_state_pkg::*;
#(
  parameter int LW = shared_state_pkg::WIDTH
) (
`ifdef SHARED_STATE_QUERY_REG_EN
  input  logic          clk,
  input  logic          rst,
`endif
  input  logic          sel,
  input  logic [LW-1:0] x_q,
  input  logic [LW-1:0] arg,
  input  logic          valid,
  output logic          res,
  output logic          res_valid
);

  logic [LW-1:0] a;
  flag_t         inv;

  always_comb begin
    a     = sel ? x_q : arg;
    inv   = '0;
    inv.x = inv_lsb(state_t'(a));
  end

`ifdef SHARED_STATE_QUERY_REG_EN
  // Result holds while the lane is idle; valid tracks the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= valid;
      if (valid) begin
        res <= inv.x;
      end
    end
  end
`else
  assign res       = inv.x;
  assign res_valid = valid;
`endif

endmodule

// File: rtl/shared_state_if_unit.sv
// Shared 32-bit state register plus NUM_Q invert-LSB query lanes.
// Define SHARED_STATE_QUERY_REG_EN for registered lane outputs.
module shared_state_if_unit
  import shared_state_pkg::*;
#(
  parameter int             WIDTH   = shared_state_pkg::WIDTH,
  parameter int             NUM_Q   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  output logic signed [WIDTH-1:0] x_q,
  output logic                    x_lsb,
  input  logic [NUM_Q-1:0]        q_sel,
  input  logic [NUM_Q*WIDTH-1:0]  q_arg,
  input  logic [NUM_Q-1:0]        q_valid,
  output logic [NUM_Q-1:0]        q_res,
  output logic [NUM_Q-1:0]        q_res_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= RST_VAL;
    end else if (wr_en) begin
      x_q <= wr_data;
    end
  end

  assign x_lsb = x_q[0];

  // Lanes read the pre-edge x_q; a same-cycle write is never bypassed.
  for (genvar i = 0; i < NUM_Q; i++) begin : g_lane
    inv_lsb_lane #(
      .LW(WIDTH)
    ) u_lane (
`ifdef SHARED_STATE_QUERY_REG_EN
      .clk       (clk),
      .rst       (rst),
`endif
      .sel       (q_sel[i]),
      .x_q       (x_q),
      .arg       (q_arg[i*WIDTH +: WIDTH]),
      .valid     (q_valid[i]),
      .res       (q_res[i]),
      .res_valid (q_res_valid[i])
    );
  end

endmodule

// File: tb/tb_shared_state_if_unit.sv
// Scoreboard bench for shared_state_if_unit, both lane build options.
module tb_shared_state_if_unit;
  import shared_state_pkg::*;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] x_q;
  logic        x_lsb;
  logic [1:0]  q_sel;
  logic [63:0] q_arg;
  logic [1:0]  q_valid;
  logic [1:0]  q_res;
  logic [1:0]  q_res_valid;

  typedef struct packed {
    logic [1:0] res;
    logic [1:0] vld;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mx;
  logic [1:0]  hold;
  int          vectors;
  int          miscompares;

  shared_state_if_unit #(
    .WIDTH(32),
    .NUM_Q(2),
    .RST_VAL('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .x_q        (x_q),
    .x_lsb      (x_lsb),
    .q_sel      (q_sel),
    .q_arg      (q_arg),
    .q_valid    (q_valid),
    .q_res      (q_res),
    .q_res_valid(q_res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (wr_en && !rst) mx = wr_data;
    #1;
  endtask

  task automatic drive(
    input logic        wr,
    input logic [31:0] wd,
    input logic [1:0]  sel,
    input logic [31:0] a0,
    input logic [31:0] a1,
    input logic [1:0]  v
  );
    exp_t       e;
    logic [1:0] comb;
    wr_en   = wr;
    wr_data = wd;
    q_sel   = sel;
    q_arg   = {a1, a0};
    q_valid = v;
    comb[0] = ~(sel[0] ? mx[0] : a0[0]);
    comb[1] = ~(sel[1] ? mx[0] : a1[0]);
`ifdef SHARED_STATE_QUERY_REG_EN
    for (int i = 0; i < 2; i++)
      if (v[i]) hold[i] = comb[i];
    e.res = hold;
`else
    e.res = comb;
`endif
    e.vld = v;
    sbq.push_back(e);
`ifdef SHARED_STATE_QUERY_REG_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic settle();
`ifndef SHARED_STATE_QUERY_REG_EN
    tick();
`endif
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    wr_en = 0; wr_data = 0; q_sel = 0; q_arg = 0; q_valid = 0;
    mx = 0; hold = 0;
    #1;
    vectors++;
    if (x_q !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_x_q got %h want 0", x_q);
    end
    vectors++;
    if (x_lsb !== 1'b0 || q_res_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_lsb_vld got %b/%b want 0/00", x_lsb, q_res_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 2'b01, 0, 0, 2'b01);
    e = sbq.pop_front();
    vectors++;
    if (q_res !== e.res || q_res_valid !== e.vld) begin
      miscompares++;
      $display("FAIL reset_query got %b/%b want %b/%b",
               q_res, q_res_valid, e.res, e.vld);
    end
    settle();
  endtask

  task automatic test_write();
    exp_t e;
    drive(1, 32'd1, 2'b00, 0, 0, 2'b00);
    void'(sbq.pop_front());
    settle();
    vectors++;
    if (x_q !== 32'd1 || x_lsb !== 1'b1) begin
      miscompares++;
      $display("FAIL write_x_q got %h/%b want 1/1", x_q, x_lsb);
    end
    drive(0, 0, 2'b10, 32'd0, 32'd0, 2'b11);
    e = sbq.pop_front();
    vectors++;
    if (q_res !== e.res || e.res !== 2'b01) begin
      miscompares++;
      $display("FAIL write_query got %b want 01", q_res);
    end
    settle();
  endtask

  task automatic test_truncation();
    exp_t e;
    drive(0, 0, 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 2'b11);
    e = sbq.pop_front();
    vectors++;
    if (q_res !== e.res || q_res !== 2'b01) begin
      miscompares++;
      $display("FAIL truncation got %b want 01", q_res);
    end
    settle();
  endtask

  task automatic test_chain();
    exp_t  e;
    flag_t f;
    f.x = x_lsb;
    drive(0, 0, 2'b00, {31'd0, f.x}, 32'd0, 2'b01);
    e = sbq.pop_front();
    vectors++;
    if (q_res[0] !== e.res[0] || q_res[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL chain got %b want 0", q_res[0]);
    end
    settle();
  endtask

  task automatic test_collision();
    exp_t e;
    drive(0, 0, 2'b01, 0, 0, 2'b01);
    void'(sbq.pop_front());
    settle();
    drive(1, 32'd0, 2'b01, 0, 0, 2'b01);
    e = sbq.pop_front();
    vectors++;
    if (q_res[0] !== 1'b0 || q_res_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_old got %b/%b want 0/1",
               q_res[0], q_res_valid[0]);
    end
    settle();
    drive(0, 0, 2'b01, 0, 0, 2'b01);
    e = sbq.pop_front();
    vectors++;
    if (q_res[0] !== e.res[0] || q_res[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_new got %b want 1", q_res[0]);
    end
    settle();
    vectors++;
    if (x_q !== 32'd0) begin
      miscompares++;
      $display("FAIL collision_x_q got %h want 0", x_q);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int n = 0; n < 24; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
            $urandom, $urandom, 2'($urandom_range(0, 3)));
      e = sbq.pop_front();
      vectors++;
      if (q_res !== e.res || q_res_valid !== e.vld) begin
        miscompares++;
        $display("FAIL b2b[%0d] got %b/%b want %b/%b",
                 n, q_res, q_res_valid, e.res, e.vld);
      end
      settle();
      vectors++;
      if (x_q !== mx) begin
        miscompares++;
        $display("FAIL b2b_x_q[%0d] got %h want %h", n, x_q, mx);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t       e;
    logic [1:0] vld_in_rst;
    drive(1, 32'd5, 2'b00, 0, 0, 2'b00);
    void'(sbq.pop_front());
    settle();
    wr_en = 0; q_sel = 2'b11; q_valid = 2'b11;
    #1;
    rst = 1'b1;
    #1;
    mx = 0; hold = 0;
    sbq.delete();
`ifdef SHARED_STATE_QUERY_REG_EN
    vld_in_rst = 2'b00;
`else
    vld_in_rst = 2'b11;
`endif
    vectors++;
    if (x_q !== 32'd0 || q_res_valid !== vld_in_rst) begin
      miscompares++;
      $display("FAIL rst_mid got %h/%b want 0/%b",
               x_q, q_res_valid, vld_in_rst);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_valid = 2'b00;
    #1;
    vectors++;
    if (q_res_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_release_vld got %b want 00", q_res_valid);
    end
    @(posedge clk);
    #1;
    drive(0, 0, 2'b01, 0, 0, 2'b01);
    e = sbq.pop_front();
    vectors++;
    if (q_res !== e.res || q_res_valid !== e.vld) begin
      miscompares++;
      $display("FAIL rst_first_req got %b/%b want %b/%b",
               q_res, q_res_valid, e.res, e.vld);
    end
    settle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write();
    test_truncation();
    test_chain();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
